tx_slot_writer: RTL and testbench

TX_SLOT_WRITER -- requirements
Module: tx_slot_writer

---
 rtl/tx_slot_writer.sv | 225 ++++++++++++++++++++++
 tb/tb_tx_slot_writer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_slot_writer.sv
// Packs a byte stream into a 16-bit slot record: data words first, then a 7-word header, then commits mem_wr_ptr.
// Optional per-frame rotate/xor hash in header words 5..6 when TX_HASH_EN is defined (words are zero otherwise).
//
// state  | meaning
// IDLE   | waiting for the first byte; goes to FULL when no room is left for a maximum record
// DATA   | packing bytes into words; bytes past 1518 are swallowed
// HDR    | writing header words B+0..B+6, one per cycle
// COMMIT | publishing the end of the record on mem_wr_ptr
// FULL   | slot region exhausted; held until reset
module tx_slot_writer (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst,
  input  logic [63:0] global_counter,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] slot_tx_eth_data,
  output logic [1:0]  slot_tx_eth_byte_en,
  output logic [13:0] slot_tx_eth_addr,
  output logic        slot_tx_eth_wr_en,
  output logic [13:0] mem_wr_ptr,
  output logic        slot_full,
  output logic        frame_trunc
);

  localparam logic [13:0] PTR_LIMIT = 14'h3FFF - 14'd766;
  localparam logic [10:0] MAX_LEN   = 11'd1518;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_HDR, S_COMMIT, S_FULL} state_t;

  state_t      state_q, state_d;
  logic [13:0] base_q, base_d;
  logic [63:0] ts_q, ts_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic        trunc_q, trunc_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [13:0] ptr_q, ptr_d;
  logic        wr_en_q, wr_en_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  be_q, be_d;
  logic        trunc_pulse_q, trunc_pulse_d;
`ifdef TX_HASH_EN
  logic [31:0] hash_q, hash_d;
`endif

  logic        accept;
  logic [13:0] data_addr;
  logic [11:0] cnt_p1;
  logic [15:0] hdr_word;

  always_comb begin
    in_ready = 1'b0;
    if (!sys_rst) begin
      case (state_q)
        S_IDLE:  in_ready = (ptr_q <= PTR_LIMIT);
        S_DATA:  in_ready = 1'b1;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  // In IDLE the byte index is 0 and the base is the current pointer.
  assign data_addr = (state_q == S_IDLE) ? (ptr_q + 14'd7)
                                         : (base_q + 14'd7 + {4'b0, cnt_q[10:1]});
  assign cnt_p1 = {1'b0, cnt_q} + 12'd1;

  always_comb begin
    hdr_word = 16'h0000;
    case (hdr_idx_q)
      3'd0: hdr_word = {5'b0, cnt_q};
      3'd1: hdr_word = ts_q[63:48];
      3'd2: hdr_word = ts_q[47:32];
      3'd3: hdr_word = ts_q[31:16];
      3'd4: hdr_word = ts_q[15:0];
`ifdef TX_HASH_EN
      3'd5: hdr_word = hash_q[31:16];
      3'd6: hdr_word = hash_q[15:0];
`endif
      default: hdr_word = 16'h0000;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    ts_d          = ts_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    trunc_d       = trunc_q;
    hdr_idx_d     = hdr_idx_q;
    ptr_d         = ptr_q;
    wr_en_d       = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;
    be_d          = be_q;
    trunc_pulse_d = 1'b0;
`ifdef TX_HASH_EN
    hash_d        = hash_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ptr_q > PTR_LIMIT) begin
          state_d = S_FULL;
        end else if (accept) begin
          base_d    = ptr_q;
          ts_d      = global_counter;
          cnt_d     = 11'd1;
          hi_d      = in_data;
          trunc_d   = 1'b0;
          hdr_idx_d = 3'd0;
`ifdef TX_HASH_EN
          hash_d    = {24'h0, in_data};
`endif
          if (in_last) begin
            wr_en_d = 1'b1;
            addr_d  = data_addr;
            data_d  = {in_data, 8'h00};
            be_d    = 2'b11;
            state_d = S_HDR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          if (cnt_q < MAX_LEN) begin
            cnt_d = cnt_q + 11'd1;
`ifdef TX_HASH_EN
            hash_d = {hash_q[26:0], hash_q[31:27]} ^ {24'h0, in_data};
`endif
            if (cnt_q[0]) begin
              wr_en_d = 1'b1;
              addr_d  = data_addr;
              data_d  = {hi_q, in_data};
              be_d    = 2'b11;
            end else begin
              hi_d = in_data;
              if (in_last) begin
                wr_en_d = 1'b1;
                addr_d  = data_addr;
                data_d  = {in_data, 8'h00};
                be_d    = 2'b11;
              end
            end
          end else begin
            trunc_d = 1'b1;
          end
          if (in_last) begin
            state_d   = S_HDR;
            hdr_idx_d = 3'd0;
          end
        end
      end
      S_HDR: begin
        wr_en_d   = 1'b1;
        addr_d    = base_q + {11'b0, hdr_idx_q};
        data_d    = hdr_word;
        be_d      = 2'b11;
        hdr_idx_d = hdr_idx_q + 3'd1;
        if (hdr_idx_q == 3'd6) begin
          state_d       = S_COMMIT;
          trunc_pulse_d = trunc_q;
        end
      end
      S_COMMIT: begin
        ptr_d   = base_q + 14'd7 + {3'b0, cnt_p1[11:1]};
        state_d = S_IDLE;
      end
      default: state_d = S_FULL;
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      ts_q          <= '0;
      cnt_q         <= '0;
      hi_q          <= '0;
      trunc_q       <= 1'b0;
      hdr_idx_q     <= '0;
      ptr_q         <= '0;
      wr_en_q       <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      be_q          <= 2'b00;
      trunc_pulse_q <= 1'b0;
`ifdef TX_HASH_EN
      hash_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      ts_q          <= ts_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      trunc_q       <= trunc_d;
      hdr_idx_q     <= hdr_idx_d;
      ptr_q         <= ptr_d;
      wr_en_q       <= wr_en_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      be_q          <= be_d;
      trunc_pulse_q <= trunc_pulse_d;
`ifdef TX_HASH_EN
      hash_q        <= hash_d;
`endif
    end
  end

  assign slot_tx_eth_wr_en   = wr_en_q;
  assign slot_tx_eth_addr    = addr_q;
  assign slot_tx_eth_data    = data_q;
  assign slot_tx_eth_byte_en = be_q;
  assign mem_wr_ptr          = ptr_q;
  assign slot_full           = (state_q == S_FULL);
  assign frame_trunc         = trunc_pulse_q;

endmodule

// File: tb/tb_tx_slot_writer.sv
// Directed bench for tx_slot_writer: a byte-level model queues every expected memory write and a monitor pops them.
`timescale 1ns/1ps
module tb_tx_slot_writer;

  logic        gmii_tx_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [63:0] global_counter = 64'h0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] slot_tx_eth_data;
  logic [1:0]  slot_tx_eth_byte_en;
  logic [13:0] slot_tx_eth_addr;
  logic        slot_tx_eth_wr_en;
  logic [13:0] mem_wr_ptr;
  logic        slot_full;
  logic        frame_trunc;

  tx_slot_writer dut (
    .gmii_tx_clk(gmii_tx_clk), .sys_rst(sys_rst), .global_counter(global_counter),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .slot_tx_eth_data(slot_tx_eth_data), .slot_tx_eth_byte_en(slot_tx_eth_byte_en),
    .slot_tx_eth_addr(slot_tx_eth_addr), .slot_tx_eth_wr_en(slot_tx_eth_wr_en),
    .mem_wr_ptr(mem_wr_ptr), .slot_full(slot_full), .frame_trunc(frame_trunc)
  );

  always #5 gmii_tx_clk = ~gmii_tx_clk;

  bit gc_run = 1'b0;
  always @(posedge gmii_tx_clk) if (gc_run) global_counter <= global_counter + 64'd1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb[$];          // {byte_en, addr, data}
  logic [7:0]  frame_q[$];
  logic [15:0] obs_mem[16384];
  logic [13:0] exp_ptr = 14'd0;
  int          trunc_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge gmii_tx_clk) begin
    #2;
    if (!sys_rst && slot_tx_eth_wr_en !== 1'b0) begin
      n_checks++;
      assert (sb.size() > 0) else begin
        n_errors++;
        $error("FAIL unexpected_write: observed addr=%0h data=%0h expected no write",
               slot_tx_eth_addr, slot_tx_eth_data);
      end
      if (sb.size() > 0) begin
        logic [31:0] exp_w;
        exp_w = sb.pop_front();
        chk("write", {slot_tx_eth_byte_en, slot_tx_eth_addr, slot_tx_eth_data}, {32'h0, exp_w});
      end
      obs_mem[slot_tx_eth_addr] = slot_tx_eth_data;
    end
    if (!sys_rst && frame_trunc === 1'b1) trunc_seen++;
  end

  // Sends the first n_send bytes of frame_q; in_last only when the whole frame is sent.
  task automatic send_frame(input int n_send, input bit gaps, output int idle_cyc);
    int          n;
    bit          full;
    int          nst;
    int          len;
    bit          ok;
    logic [13:0] b;
    logic [63:0] ts;
    logic [31:0] h;
    n = frame_q.size();
    full = (n_send == n);
    nst = (n_send < 1518) ? n_send : 1518;
    b = exp_ptr;
    ts = 64'h0;
    h = 32'h0;
    idle_cyc = 0;
    trunc_seen = 0;
    for (int i = 0; i < nst; i++) begin
      h = {h[26:0], h[31:27]} ^ {24'h0, frame_q[i]};
      if (i % 2 == 1)
        sb.push_back({2'b11, b + 14'd7 + 14'(i / 2), frame_q[i-1], frame_q[i]});
      else if (full && i == n - 1)
        sb.push_back({2'b11, b + 14'd7 + 14'(i / 2), frame_q[i], 8'h00});
    end
    for (int i = 0; i < n_send; i++) begin
      if (gaps && i > 0) @(negedge gmii_tx_clk);
      in_valid = 1'b1;
      in_data  = frame_q[i];
      in_last  = full && (i == n - 1);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        #1;
        if (in_ready === 1'b1) begin
          ok = 1'b1;
          if (i == 0) ts = global_counter;
          break;
        end
        @(negedge gmii_tx_clk);
      end
      if (ok) @(negedge gmii_tx_clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!ok) begin
        chk("accept_timeout", {63'h0, ok}, 64'h1);
        return;
      end
    end
    if (full) begin
      len = (n < 1518) ? n : 1518;
      sb.push_back({2'b11, b, 16'(len)});
      sb.push_back({2'b11, b + 14'd1, ts[63:48]});
      sb.push_back({2'b11, b + 14'd2, ts[47:32]});
      sb.push_back({2'b11, b + 14'd3, ts[31:16]});
      sb.push_back({2'b11, b + 14'd4, ts[15:0]});
`ifdef TX_HASH_EN
      sb.push_back({2'b11, b + 14'd5, h[31:16]});
      sb.push_back({2'b11, b + 14'd6, h[15:0]});
`else
      sb.push_back({2'b11, b + 14'd5, 16'h0000});
      sb.push_back({2'b11, b + 14'd6, 16'h0000});
`endif
      exp_ptr = b + 14'd7 + 14'((len + 1) / 2);
      for (int k = 0; k < 40; k++) begin
        #1;
        if (in_ready === 1'b1 || slot_full === 1'b1) break;
        idle_cyc++;
        @(negedge gmii_tx_clk);
      end
      chk("mem_wr_ptr", {50'h0, mem_wr_ptr}, {50'h0, exp_ptr});
      chk("trunc_pulses", 64'(trunc_seen), (n > 1518) ? 64'd1 : 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);
    end
  endtask

  task automatic fill_random(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    int          idle;
    int          diffs;
    logic [13:0] b1, b2;
    int          guard;

    // Reset state
    repeat (3) @(negedge gmii_tx_clk);
    #1;
    chk("rst_wr_en", {63'h0, slot_tx_eth_wr_en}, 64'h0);
    chk("rst_data", {48'h0, slot_tx_eth_data}, 64'h0);
    chk("rst_addr", {50'h0, slot_tx_eth_addr}, 64'h0);
    chk("rst_be", {62'h0, slot_tx_eth_byte_en}, 64'h0);
    chk("rst_ptr", {50'h0, mem_wr_ptr}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
    chk("rst_full", {63'h0, slot_full}, 64'h0);
    chk("rst_trunc", {63'h0, frame_trunc}, 64'h0);
    sys_rst = 1'b0;
    @(negedge gmii_tx_clk);
    #1;
    chk("idle_in_ready", {63'h0, in_ready}, 64'h1);
    @(negedge gmii_tx_clk);

    // 4-byte frame with a fixed timestamp
    global_counter = 64'h0000_0001_0002_0003;
    frame_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(4, 1'b0, idle);
    chk("ptr_after_f1", {50'h0, mem_wr_ptr}, 64'd9);

    // 3-byte frame: odd length pads the last word
    frame_q = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(3, 1'b0, idle);
    chk("ptr_after_f2", {50'h0, mem_wr_ptr}, 64'd18);
    chk("obs_16", {48'h0, obs_mem[16]}, 64'hAABB);
    chk("obs_17", {48'h0, obs_mem[17]}, 64'hCC00);

    // Hash frame 01 02
    gc_run = 1'b1;
    frame_q = '{8'h01, 8'h02};
    b1 = exp_ptr;
    send_frame(2, 1'b0, idle);
`ifdef TX_HASH_EN
    chk("hash_lo", {48'h0, obs_mem[b1 + 14'd6]}, 64'h0022);
`else
    chk("hash_lo", {48'h0, obs_mem[b1 + 14'd6]}, 64'h0000);
`endif

    // Single-byte frame
    frame_q = '{8'h5A};
    send_frame(1, 1'b0, idle);

    // 60-byte frame gap-free, then the same bytes with in_valid toggling
    fill_random(60);
    b1 = exp_ptr;
    send_frame(60, 1'b0, idle);
    b2 = exp_ptr;
    send_frame(60, 1'b1, idle);
    chk("ready_low_after_last", 64'(idle), 64'd8);
    diffs = 0;
    for (int i = 0; i < 30; i++)
      if (obs_mem[b1 + 14'd7 + 14'(i)] !== obs_mem[b2 + 14'd7 + 14'(i)]) diffs++;
    chk("gap_image_match", 64'(diffs), 64'd0);

    // 1600-byte frame truncated to 1518
    fill_random(1600);
    b1 = exp_ptr;
    send_frame(1600, 1'b0, idle);
    chk("trunc_advance", {50'h0, mem_wr_ptr - b1}, 64'd766);
    chk("trunc_len", {48'h0, obs_mem[b1]}, 64'd1518);

    // Reset mid-frame discards the partial record
    fill_random(10);
    send_frame(4, 1'b0, idle);
    repeat (2) @(negedge gmii_tx_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge gmii_tx_clk);
    #1;
    chk("midrst_ptr", {50'h0, mem_wr_ptr}, 64'h0);
    chk("midrst_sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();
    sys_rst = 1'b0;
    exp_ptr = 14'd0;
    @(negedge gmii_tx_clk);
    frame_q = '{8'hDE, 8'hAD};
    send_frame(2, 1'b0, idle);
    chk("ptr_after_midrst", {50'h0, mem_wr_ptr}, 64'd8);

    // Stream frames until the slot region is exhausted
    guard = 0;
    while (exp_ptr <= 14'd15617 && guard < 30) begin
      fill_random(1518);
      send_frame(1518, 1'b0, idle);
      guard++;
    end
    repeat (2) @(negedge gmii_tx_clk);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("full_flag", {63'h0, slot_full}, 64'h1);
      chk("full_in_ready", {63'h0, in_ready}, 64'h0);
      @(negedge gmii_tx_clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    sys_rst = 1'b1;
    @(negedge gmii_tx_clk);
    #1;
    chk("fullrst_in_ready", {63'h0, in_ready}, 64'h0);
    chk("fullrst_full", {63'h0, slot_full}, 64'h0);
    chk("fullrst_ptr", {50'h0, mem_wr_ptr}, 64'h0);
    sys_rst = 1'b0;
    @(negedge gmii_tx_clk);
    #1;
    chk("post_full_ready", {63'h0, in_ready}, 64'h1);
    repeat (2) @(negedge gmii_tx_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
